// File: rtl/debug_watch_scanner.sv
// Debug-watch scanner: steps a register index and a memory word address on a
// divided tick enable, and muxes a one-hot selected channel onto a tagged display word.
module debug_watch_scanner #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_NUM   = 32,
  parameter int MEM_BASE  = 0,
  parameter int MEM_WORDS = 64,
  parameter int DIV_W     = 28,
  parameter int FAST_BIT  = 24,
  parameter int SLOW_BIT  = 27,
  parameter int REG_CH    = 2,
  parameter int MEM_CH    = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         slow,
  input  logic                         freeze,
  input  logic                         step,
  input  logic [NUM_CH-1:0]            sel,
  input  logic [NUM_CH*DATA_W-1:0]     ch_data,
  output logic [$clog2(REG_NUM)-1:0]   reg_idx,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [63:0]                  disp_data,
  output logic                         tick
);

  localparam int RW = $clog2(REG_NUM);
  localparam logic [RW-1:0]     REG_LAST  = RW'(REG_NUM - 1);
  localparam logic [ADDR_W-1:0] MEM_FIRST = ADDR_W'(MEM_BASE);
  localparam logic [ADDR_W-1:0] MEM_LAST  = ADDR_W'(MEM_BASE + 4 * (MEM_WORDS - 1));

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  function automatic logic onehot_f(input logic [NUM_CH-1:0] v);
    return (v != {NUM_CH{1'b0}}) && ((v & (v - NUM_CH'(1))) == {NUM_CH{1'b0}});
  endfunction

  logic [DIV_W-1:0]  div_r;
  logic              src_q_r;
  logic              slow_q_r;
  logic              step_q_r;
  state_t            state_r;
  logic [RW-1:0]     reg_idx_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [63:0]       disp_r;
  logic              tick_r;

  logic              src_s;
  logic              adv_auto_s;
  logic              adv_s;
  state_t            state_nxt_s;
  logic [RW-1:0]     reg_nxt_s;
  logic [ADDR_W-1:0] mem_nxt_s;
  logic [31:0]       data_s;
  logic [31:0]       tag_s;
  logic [63:0]       disp_nxt_s;

  // Tick source selection; a change of slow masks the edge detector for one cycle
  always_comb begin
    src_s      = slow ? div_r[SLOW_BIT] : div_r[FAST_BIT];
    adv_auto_s = src_s & ~src_q_r & ~(slow ^ slow_q_r);
  end

  // Run/freeze control: choose advance source and next state
  always_comb begin
    adv_s       = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        adv_s       = adv_auto_s;
        state_nxt_s = freeze ? ST_FROZEN : ST_RUN;
      end
      ST_FROZEN: begin
        adv_s       = step & ~step_q_r;
        state_nxt_s = freeze ? ST_FROZEN : ST_RUN;
      end
      default: begin
        adv_s       = 1'b0;
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Scan position next values; wrap and increment share the same edge
  always_comb begin
    reg_nxt_s = reg_idx_r;
    mem_nxt_s = mem_addr_r;
    if (adv_s) begin
      reg_nxt_s = (reg_idx_r == REG_LAST) ? {RW{1'b0}} : reg_idx_r + RW'(1);
      mem_nxt_s = (mem_addr_r == MEM_LAST) ? MEM_FIRST : mem_addr_r + ADDR_W'(4);
    end else begin
      reg_nxt_s = reg_idx_r;
      mem_nxt_s = mem_addr_r;
    end
  end

  // Display word: tag uses the pre-advance position so it lines up with the data
  always_comb begin
    data_s = 32'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      data_s = data_s | (sel[k] ? 32'(ch_data[k*DATA_W +: DATA_W]) : 32'd0);
    end
    tag_s      = sel[REG_CH] ? 32'(reg_idx_r) : (sel[MEM_CH] ? 32'(mem_addr_r) : 32'd0);
    disp_nxt_s = onehot_f(sel) ? {tag_s, data_s} : 64'd0;
  end

  // All state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_r      <= {DIV_W{1'b0}};
      src_q_r    <= 1'b0;
      slow_q_r   <= 1'b0;
      step_q_r   <= 1'b0;
      state_r    <= ST_RUN;
      reg_idx_r  <= {RW{1'b0}};
      mem_addr_r <= MEM_FIRST;
      disp_r     <= 64'd0;
      tick_r     <= 1'b0;
    end else begin
      div_r      <= div_r + DIV_W'(1);
      src_q_r    <= src_s;
      slow_q_r   <= slow;
      step_q_r   <= step;
      state_r    <= state_nxt_s;
      reg_idx_r  <= reg_nxt_s;
      mem_addr_r <= mem_nxt_s;
      disp_r     <= disp_nxt_s;
      tick_r     <= adv_s;
    end
  end

  assign reg_idx   = reg_idx_r;
  assign mem_addr  = mem_addr_r;
  assign disp_data = disp_r;
  assign tick      = tick_r;

endmodule

// File: tb/tb_debug_watch_scanner.sv
// Bench for debug_watch_scanner: random stimulus checked cycle by cycle against an
// arithmetic model of the scan position, plus directed checks of tick timing and display tags.
module tb_debug_watch_scanner;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int REG_NUM   = 5;
  localparam int MEM_BASE  = 'h100;
  localparam int MEM_WORDS = 3;
  localparam int DIV_W     = 6;
  localparam int FAST_BIT  = 2;
  localparam int SLOW_BIT  = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         slow = 1'b0;
  logic         freeze = 1'b0;
  logic         step = 1'b0;
  logic [3:0]   sel = 4'b0100;
  logic [127:0] ch_data = 128'd0;
  logic [2:0]   reg_idx;
  logic [31:0]  mem_addr;
  logic [63:0]  disp_data;
  logic         tick;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: cycles since reset release and number of advances taken
  int          m_cnt, m_pos, edges;
  bit          m_prev_src, m_prev_slow, m_prev_step, m_frozen, m_tick;
  logic [63:0] m_disp;
  int          obs_edge[$];
  int          obs_reg[$];
  int          obs_mem[$];

  debug_watch_scanner #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM),
    .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS), .DIV_W(DIV_W),
    .FAST_BIT(FAST_BIT), .SLOW_BIT(SLOW_BIT), .REG_CH(2), .MEM_CH(0)
  ) dut (
    .clk(clk), .rstn(rstn), .slow(slow), .freeze(freeze), .step(step),
    .sel(sel), .ch_data(ch_data), .reg_idx(reg_idx), .mem_addr(mem_addr),
    .disp_data(disp_data), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_disp();
    int idx;
    logic [31:0] tag;
    if ($countones(sel) != 1) return 64'd0;
    idx = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
    if (idx == 2)      tag = 32'(m_pos % REG_NUM);
    else if (idx == 0) tag = 32'(MEM_BASE + 4 * (m_pos % MEM_WORDS));
    else               tag = 32'd0;
    return {tag, ch_data[idx*32 +: 32]};
  endfunction

  task automatic run_cycle();
    int d;
    bit src, adv_auto, adv;
    logic [63:0] nd;
    d        = m_cnt % (1 << DIV_W);
    src      = slow ? (((d >> SLOW_BIT) % 2) == 1) : (((d >> FAST_BIT) % 2) == 1);
    adv_auto = src && !m_prev_src && (slow == m_prev_slow);
    adv      = m_frozen ? (step && !m_prev_step) : adv_auto;
    nd       = exp_disp();
    @(posedge clk);
    m_prev_src  = src;
    m_prev_slow = slow;
    m_prev_step = step;
    m_frozen    = freeze;
    if (adv) m_pos++;
    m_tick = adv;
    m_disp = nd;
    m_cnt++;
    edges++;
    #1;
    check_val("reg_idx", 64'(reg_idx), 64'(m_pos % REG_NUM));
    check_val("mem_addr", 64'(mem_addr), 64'(MEM_BASE + 4 * (m_pos % MEM_WORDS)));
    check_val("tick", 64'(tick), 64'(m_tick));
    check_val("disp_data", disp_data, m_disp);
    if (tick) begin
      obs_edge.push_back(edges);
      obs_reg.push_back(int'(reg_idx));
      obs_mem.push_back(int'(mem_addr));
    end
  endtask

  task automatic clear_obs();
    obs_edge.delete();
    obs_reg.delete();
    obs_mem.delete();
  endtask

  task automatic async_reset();
    #2;
    rstn = 1'b0;
    #1;
    check_val("rst_reg_idx", 64'(reg_idx), 64'd0);
    check_val("rst_mem_addr", 64'(mem_addr), 64'h100);
    check_val("rst_disp", disp_data, 64'd0);
    check_val("rst_tick", 64'(tick), 64'd0);
    m_cnt = 0; m_pos = 0; edges = 0;
    m_prev_src = 0; m_prev_slow = 0; m_prev_step = 0; m_frozen = 0; m_tick = 0;
    m_disp = 64'd0;
    clear_obs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int sw_done, p0, guard;
    int exp_reg[6];
    int exp_mem[6];
    exp_reg = '{1, 2, 3, 4, 0, 1};
    exp_mem = '{'h104, 'h108, 'h100, 'h104, 'h108, 'h100};

    async_reset();

    // run with fast source, random one-hot selects
    for (int c = 0; c < 200 && obs_edge.size() < 6; c++) begin
      ch_data = {$urandom, $urandom, $urandom, $urandom};
      sel     = 4'b0001 << $urandom_range(3, 0);
      run_cycle();
    end
    check_val("tick_count_run", 64'(obs_edge.size() >= 6), 64'd1);
    if (obs_edge.size() >= 6) begin
      check_val("first_tick_edge", 64'(obs_edge[0]), 64'd5);
      for (int i = 1; i < 6; i++) check_val("fast_period", 64'(obs_edge[i] - obs_edge[i-1]), 64'd8);
      for (int i = 0; i < 6; i++) begin
        check_val("wrap_reg_seq", 64'(obs_reg[i]), 64'(exp_reg[i]));
        check_val("wrap_mem_seq", 64'(obs_mem[i]), 64'(exp_mem[i]));
      end
    end

    // switch to slow exactly when the fast bit rises
    sw_done = 0;
    for (int c = 0; c < 64 && sw_done == 0; c++) begin
      if ((m_cnt % 8) == 4) begin
        slow = 1'b1;
        run_cycle();
        check_val("switch_no_tick", 64'(tick), 64'd0);
        sw_done = 1;
      end else begin
        run_cycle();
      end
    end
    check_val("switch_found", 64'(sw_done), 64'd1);
    clear_obs();
    for (int c = 0; c < 130 && obs_edge.size() < 3; c++) run_cycle();
    check_val("tick_count_slow", 64'(obs_edge.size() >= 3), 64'd1);
    if (obs_edge.size() >= 3) begin
      check_val("slow_period", 64'(obs_edge[1] - obs_edge[0]), 64'd32);
      check_val("slow_period", 64'(obs_edge[2] - obs_edge[1]), 64'd32);
    end

    // freeze, then single-step with wide pulses
    slow   = 1'b0;
    freeze = 1'b1;
    run_cycle();
    run_cycle();
    clear_obs();
    repeat (100) run_cycle();
    check_val("frozen_ticks", 64'(obs_edge.size()), 64'd0);
    p0 = m_pos;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      repeat (4) run_cycle();
      step = 1'b0;
      repeat (4) run_cycle();
    end
    check_val("step_ticks", 64'(obs_edge.size()), 64'd3);
    check_val("step_reg", 64'(reg_idx), 64'((p0 + 3) % REG_NUM));

    // display tags, stepping until the register index reads 3
    guard = 0;
    while ((m_pos % REG_NUM) != 3 && guard < 10) begin
      step = 1'b1; run_cycle();
      step = 1'b0; run_cycle();
      guard++;
    end
    sel = 4'b0100; ch_data = 128'd0; ch_data[95:64] = 32'hDEADBEEF;
    run_cycle();
    check_val("disp_reg_tag", disp_data, 64'h00000003_DEADBEEF);
    sel = 4'b1000; ch_data[127:96] = 32'h12345678;
    run_cycle();
    check_val("disp_plain_ch", disp_data, 64'h00000000_12345678);
    sel = 4'b0011;
    run_cycle();
    check_val("disp_multi_sel", disp_data, 64'd0);
    sel = 4'b0000;
    run_cycle();
    check_val("disp_no_sel", disp_data, 64'd0);
    sel = 4'b0001; ch_data[31:0] = 32'hCAFEF00D;
    run_cycle();
    check_val("disp_mem_tag", disp_data, {32'(MEM_BASE + 4 * (m_pos % MEM_WORDS)), 32'hCAFEF00D});

    // random mix of freeze, step, slow and selects
    for (int c = 0; c < 1500; c++) begin
      ch_data = {$urandom, $urandom, $urandom, $urandom};
      sel     = ($urandom_range(3, 0) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(3, 0));
      if ($urandom_range(39, 0) == 0) freeze = ~freeze;
      if ($urandom_range(3, 0) == 0) step = ~step;
      if ($urandom_range(99, 0) == 0) slow = ~slow;
      run_cycle();
    end

    // reset in the middle of a scan while reg_idx is 4
    freeze = 1'b0; slow = 1'b0; step = 1'b0;
    guard = 0;
    while (!((m_pos % REG_NUM) == 4 && m_tick == 0) && guard < 400) begin
      run_cycle();
      guard++;
    end
    check_val("pre_reset_idx", 64'(reg_idx), 64'd4);
    async_reset();
    for (int c = 0; c < 20; c++) run_cycle();
    check_val("post_reset_ticks", 64'(obs_edge.size() >= 1), 64'd1);
    if (obs_edge.size() >= 1) check_val("post_reset_first_tick", 64'(obs_edge[0]), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
